// File: rtl/alu_2bit_pkg.sv
// Shared constants for the 2-bit ALU exhaustive checker: opcodes, sweep size
// and the sequencer state encoding.
package alu_2bit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int NUM_VEC = 64;
  localparam int VEC_W   = 6;
  localparam int ERR_W   = 7;

  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/alu_2bit_model.sv
// Golden 2-bit ALU: the value the checker expects for a given {sel, a, b}.
module alu_2bit_model
  import alu_2bit_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] sel,
  output logic [2:0] exp
);

  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives the output and no latch is inferred.
  always_comb begin
    exp = '0;
    unique case (sel)
      OP_AND: exp = {1'b0, a & b};
      OP_OR:  exp = {1'b0, a | b};
      OP_ADD: exp = {1'b0, a} + {1'b0, b};
      OP_SUB: exp = {1'b0, a} - {1'b0, b};  // wraps mod 8
    endcase
  end

endmodule

// File: rtl/alu_2bit_checker.sv
// Exhaustive 64-vector sweep checker for an external 2-bit ALU.
// Optional first-mismatch capture on fail_vec when ALU_CHK_FAILCAP_EN is defined.
module alu_2bit_checker
  import alu_2bit_pkg::*;
#(
  parameter int SETTLE = 1  // 1..7 cycles between driving a vector and sampling
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       a_o,
  output logic [1:0]       b_o,
  output logic [1:0]       sel_o,
  input  logic [2:0]       result_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [2:0]       exp_val;
  logic             mismatch;
  logic             start_accept;

  alu_2bit_model u_model (
    .a   (idx_q[3:2]),
    .b   (idx_q[1:0]),
    .sel (idx_q[5:4]),
    .exp (exp_val)
  );

  // Operands come straight from idx, which only moves on CHECK->DRIVE,
  // so the vector is stable for its whole DRIVE..CHECK window.
  assign sel_o = idx_q[5:4];
  assign a_o   = idx_q[3:2];
  assign b_o   = idx_q[1:0];

  assign mismatch     = (result_i != exp_val);
  assign start_accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      CHECK: begin
        if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
        if (idx_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + VEC_W'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking '<=' and a synchronous reset tested
  // first, so rst wins over a start sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef ALU_CHK_FAILCAP_EN
  logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
  logic             fail_vld_q, fail_vld_d;

  always_comb begin
    fail_vec_d = fail_vec_q;
    fail_vld_d = fail_vld_q;
    if (start_accept) begin
      fail_vec_d = '0;
      fail_vld_d = 1'b0;
    end else if ((state_q == CHECK) && mismatch && !fail_vld_q) begin
      fail_vec_d = idx_q;
      fail_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vec_q <= '0;
      fail_vld_q <= 1'b0;
    end else begin
      fail_vec_q <= fail_vec_d;
      fail_vld_q <= fail_vld_d;
    end
  end

  assign fail_vec = fail_vec_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_alu_2bit_checker.sv
// Scoreboard bench for alu_2bit_checker: a bench-side ALU with per-vector
// overrides is swept; expected sweep outcomes are queued and a monitor compares.
module tb_alu_2bit_checker;

  typedef struct {
    int done_cyc;
    int err;
    bit pass;
    int fvec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, start3;
  logic [1:0] a_o, b_o, sel_o, a3, b3, sel3;
  logic [2:0] result1, result3, pipe1, pipe2;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [6:0] err_count, err3;
  logic [5:0] fail_vec, fv3;
  logic [5:0] vec1;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] ovr [64];  // bit3 = override valid, [2:0] = forced ALU output

  exp_t q1[$];
  exp_t q3[$];
  exp_t cur1, cur3;
  bit   pend1 = 1'b0;
  bit   pend3 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_2bit_checker #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a_o), .b_o(b_o), .sel_o(sel_o), .result_i(result1),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  alu_2bit_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a_o(a3), .b_o(b3), .sel_o(sel3), .result_i(result3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vec(fv3)
  );

  function automatic logic [2:0] golden(input int sel, input int a, input int b);
    case (sel)
      0:       return 3'(a & b);
      1:       return 3'(a | b);
      2:       return 3'(a + b);
      default: return 3'((a - b + 8) % 8);
    endcase
  endfunction

  assign vec1 = {sel_o, a_o, b_o};
  always_comb begin
    if (ovr[vec1][3]) result1 = ovr[vec1][2:0];
    else              result1 = golden(int'(sel_o), int'(a_o), int'(b_o));
  end

  // Second ALU answers two clock edges after its operands change.
  always @(posedge clk) begin
    pipe1 <= golden(int'(sel3), int'(a3), int'(b3));
    pipe2 <= pipe1;
  end
  assign result3 = pipe2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Outcome of a sweep started at the negedge where cyc == start_cyc.
  function automatic exp_t model(input int start_cyc, input int settle, input bit use_ovr);
    exp_t e;
    int   first = 0;
    e.err = 0;
    for (int i = 0; i < 64; i++) begin
      logic [2:0] g;
      g = golden(i >> 4, (i >> 2) & 3, i & 3);
      if (use_ovr && ovr[i][3] && (ovr[i][2:0] != g)) begin
        if (e.err == 0) first = i;
        e.err++;
      end
    end
    e.pass     = (e.err == 0);
`ifdef ALU_CHK_FAILCAP_EN
    e.fvec     = first;
`else
    e.fvec     = 0;
`endif
    e.done_cyc = start_cyc + 1 + 64 * (settle + 2);
    return e;
  endfunction

  initial forever begin
    @(negedge clk);
    if (pend1) begin
      check("pass", pass, cur1.pass);
      check("fail_vec", fail_vec, cur1.fvec);
      check("busy_after_done", busy, 0);
      pend1 = 1'b0;
    end
    if (done === 1'b1) begin
      if (q1.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        cur1 = q1.pop_front();
        check("done_cycle", cyc, cur1.done_cyc);
        check("err_count", err_count, cur1.err);
        pend1 = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (pend3) begin
      check("pass_s3", pass3, cur3.pass);
      pend3 = 1'b0;
    end
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        check("unexpected_done_s3", 1, 0);
      end else begin
        cur3 = q3.pop_front();
        check("done_cycle_s3", cyc, cur3.done_cyc);
        check("err_count_s3", err3, cur3.err);
        pend3 = 1'b1;
      end
    end
  end

  task automatic wait_idle1();
    int n = 0;
    while ((q1.size() != 0 || pend1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("timeout_sweep", 1, 0);
    @(negedge clk);
  endtask

  task automatic sweep(input bit poke);
    @(negedge clk);
    q1.push_back(model(cyc, 1, 1'b1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_running", busy, 1);
    check("first_vec", vec1, 0);
    if (poke) begin
      repeat ($urandom_range(5, 150)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle1();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fail_vec"}, fail_vec, 0);
    check({tag, "_vec"}, vec1, 0);
  endtask

  task automatic clear_ovr();
    for (int i = 0; i < 64; i++) ovr[i] = 4'h0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    clear_ovr();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_busy_s3", busy3, 0);
    rst = 1'b0;

    // Correct ALU.
    sweep(1'b0);

    // SUB stuck at zero: the four a==b vectors still match, so 12 mismatches,
    // the first one at sel=11 a=00 b=01.
    for (int i = 48; i < 64; i++) ovr[i] = 4'b1000;
    sweep(1'b0);

    // ALU gives exactly the required answers at {10,11,10} and {11,00,01}.
    clear_ovr();
    ovr[6'b101110] = 4'b1101;
    ovr[6'b110001] = 4'b1111;
    sweep(1'b0);

    // One wrong answer at {10,11,10}.
    clear_ovr();
    ovr[6'b101110] = 4'b1100;
    sweep(1'b0);

    // Random corruption, one sweep poked with a start while busy.
    for (int s = 0; s < 3; s++) begin
      clear_ovr();
      for (int i = 0; i < 64; i++)
        if ($urandom_range(0, 7) == 0) ovr[i] = {1'b1, 3'($urandom)};
      sweep(s == 1);
    end

    // Abort mid-sweep: no done may follow (the monitor flags any).
    clear_ovr();
    ovr[6'd7] = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_reset_outputs("abort");
    repeat (250) @(negedge clk);
    check("abort_still_idle", busy, 0);
    clear_ovr();
    sweep(1'b0);

    // SETTLE=3 against the delayed ALU.
    @(negedge clk);
    q3.push_back(model(cyc, 3, 1'b0));
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    begin
      int n = 0;
      while ((q3.size() != 0 || pend3) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) check("timeout_sweep_s3", 1, 0);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
